// File: rtl/cpu_trace_buffer.sv
// Instruction/register-write trace capture FIFO with first-word-fall-through head.
// Captures that arrive while the FIFO is full (and not popping) are counted as drops.
module cpu_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter bit ALL_INSNS = 1'b0,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          capture_en,
  input  logic          clear,
  input  logic [31:0]   pc,
  input  logic [31:0]   inst,
  input  logic          w,
  input  logic [4:0]    waddr,
  input  logic [31:0]   wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_wdata,
  output logic [4:0]    out_waddr,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;

  logic   push_req, pop, full, do_push;
  entry_t wr_ent, head;

  assign push_req = capture_en & (ALL_INSNS | (w & (waddr != 5'd0)));
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (count_q != '0) & out_ready;
  assign do_push  = push_req & (~full | pop) & ~clear;
  assign wr_ent   = '{pc: pc, inst: inst,
                      waddr: w ? waddr : 5'd0, wdata: w ? wdata : 32'd0};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (pop)     rptr_d = rptr_q + 1'b1;
      if (do_push && !pop)      count_d = count_q + 1'b1;
      else if (!do_push && pop) count_d = count_q - 1'b1;
      // A full FIFO that pops this edge still has room for the new entry.
      if (push_req && full && !pop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is left unreset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q] <= wr_ent;
  end

  assign head      = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign out_valid = (count_q != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_waddr = head.waddr;
  assign out_wdata = head.wdata;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios plus random traffic against a queue model,
// driving a 16-deep reg-write-only instance and a 4-deep every-instruction instance in parallel.
module tb_cpu_trace_buffer;
  logic        clk_in = 1'b0, reset = 1'b1, capture_en = 1'b0, clear = 1'b0;
  logic        w = 1'b0, out_ready = 1'b0;
  logic [31:0] pc = '0, inst = '0, wdata = '0;
  logic [4:0]  waddr = '0;

  logic        v0, v1, ovf0, ovf1;
  logic [31:0] pc0, pc1, in0, in1, wd0, wd1;
  logic [4:0]  wa0, wa1, cnt0;
  logic [2:0]  cnt1;
  logic [15:0] dr0, dr1;

  always #5 clk_in = ~clk_in;

  cpu_trace_buffer #(.DEPTH(16), .ALL_INSNS(1'b0)) u0 (
    .clk_in(clk_in), .reset(reset), .capture_en(capture_en), .clear(clear),
    .pc(pc), .inst(inst), .w(w), .waddr(waddr), .wdata(wdata),
    .out_valid(v0), .out_ready(out_ready), .out_pc(pc0), .out_inst(in0),
    .out_wdata(wd0), .out_waddr(wa0), .count(cnt0), .overflow(ovf0), .drop_cnt(dr0));

  cpu_trace_buffer #(.DEPTH(4), .ALL_INSNS(1'b1)) u1 (
    .clk_in(clk_in), .reset(reset), .capture_en(capture_en), .clear(clear),
    .pc(pc), .inst(inst), .w(w), .waddr(waddr), .wdata(wdata),
    .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_inst(in1),
    .out_wdata(wd1), .out_waddr(wa1), .count(cnt1), .overflow(ovf1), .drop_cnt(dr1));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t mq0[$], mq1[$];
  bit   movf[2];
  int   mdrop[2];
  int   checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete();
    movf  = '{0, 0};
    mdrop = '{0, 0};
  endtask

  // One clock edge of a FIFO of the given depth and capture mode.
  task automatic model_one(input int k, input int dep, input bit all, inout ent_t q[$]);
    bit   push, pop;
    ent_t e;
    if (clear) begin
      q.delete(); movf[k] = 0; mdrop[k] = 0;
      return;
    end
    push = capture_en && (all || (w && waddr != 0));
    pop  = (q.size() > 0) && out_ready;
    e = '{pc: pc, inst: inst, wa: w ? waddr : 5'd0, wd: w ? wdata : 32'd0};
    if (push && q.size() == dep && !pop) begin
      movf[k] = 1;
      if (mdrop[k] < 65535) mdrop[k]++;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic check_inst(input int k, input ent_t q[$], input logic v, input logic [31:0] opc,
                            input logic [31:0] oin, input logic [4:0] owa, input logic [31:0] owd,
                            input logic [31:0] ocnt, input logic oovf, input logic [15:0] odr);
    ent_t h;
    h = '{pc: 0, inst: 0, wa: 0, wd: 0};
    if (q.size() > 0) h = q[0];
    chk($sformatf("u%0d.out_valid", k), 32'(v), 32'(q.size() > 0));
    chk($sformatf("u%0d.count", k), ocnt, q.size());
    chk($sformatf("u%0d.out_pc", k), opc, h.pc);
    chk($sformatf("u%0d.out_inst", k), oin, h.inst);
    chk($sformatf("u%0d.out_waddr", k), 32'(owa), 32'(h.wa));
    chk($sformatf("u%0d.out_wdata", k), owd, h.wd);
    chk($sformatf("u%0d.overflow", k), 32'(oovf), 32'(movf[k]));
    chk($sformatf("u%0d.drop_cnt", k), 32'(odr), mdrop[k]);
  endtask

  task automatic check_all();
    check_inst(0, mq0, v0, pc0, in0, wa0, wd0, 32'(cnt0), ovf0, dr0);
    check_inst(1, mq1, v1, pc1, in1, wa1, wd1, 32'(cnt1), ovf1, dr1);
  endtask

  task automatic set_in(input logic ce, input logic clr, input logic rdy, input logic [31:0] p,
                        input logic [31:0] i, input logic ww, input logic [4:0] wa,
                        input logic [31:0] wd);
    capture_en = ce; clear = clr; out_ready = rdy;
    pc = p; inst = i; w = ww; waddr = wa; wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_one(0, 16, 1'b0, mq0);
    model_one(1, 4, 1'b1, mq1);
    #1;
    check_all();
  endtask

  initial begin
    model_clear();
    #12;
    check_all();
    chk("reset_valid", 32'(v0), 0);
    reset = 1'b0;

    // Single register-write capture, held at the head.
    set_in(1, 0, 0, 32'h00400000, 32'h20080005, 1, 5'd8, 32'd5);
    tick();
    chk("push1_valid", 32'(v0), 1);
    chk("push1_pc", pc0, 32'h00400000);
    chk("push1_waddr", 32'(wa0), 8);
    chk("push1_wdata", wd0, 5);
    chk("push1_count", 32'(cnt0), 1);

    // Writes to x0 and non-writing instructions are ignored in reg-write mode.
    set_in(0, 1, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 32'h10, 32'h11, 1, 5'd0, 32'h12); tick();
    set_in(1, 0, 0, 32'h14, 32'h15, 0, 5'd9, 32'h16); tick();
    chk("nopush_count", 32'(cnt0), 0);

    // Overfill with the consumer stalled, then drain in order.
    set_in(0, 1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 0, 32'h1000 + 4 * i, i, 1, 5'd8, i); tick();
    end
    chk("fill_count", 32'(cnt0), 16);
    chk("fill_ovf", 32'(ovf0), 1);
    chk("fill_drop", 32'(dr0), 4);
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 1, 0, 0, 0, 0, 0);
      chk("drain_pc", pc0, 32'h1000 + 4 * i);
      tick();
    end
    chk("drain_count", 32'(cnt0), 0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 0, 32'h2000 + 4 * i, i, 1, 5'd3, i); tick();
    end
    set_in(1, 0, 1, 32'h3000, 32'h3, 1, 5'd4, 32'h33); tick();
    chk("fullpp_count", 32'(cnt0), 16);
    chk("fullpp_drop", 32'(dr0), 4);
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 1, 0, 0, 0, 0, 0);
      if (i == 15) chk("fullpp_tail_pc", pc0, 32'h3000);
      tick();
    end

    // Clear wins over a concurrent push.
    set_in(0, 1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 19; i++) begin
      set_in(1, 0, 0, 32'h4000 + 4 * i, i, 1, 5'd1, i); tick();
    end
    for (int i = 0; i < 11; i++) begin
      set_in(0, 0, 1, 0, 0, 0, 0, 0); tick();
    end
    chk("preclr_count", 32'(cnt0), 5);
    chk("preclr_drop", 32'(dr0), 3);
    set_in(1, 1, 1, 32'h4444, 32'h1, 1, 5'd2, 32'h2); tick();
    chk("clr_count", 32'(cnt0), 0);
    chk("clr_valid", 32'(v0), 0);
    chk("clr_ovf", 32'(ovf0), 0);
    chk("clr_drop", 32'(dr0), 0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0, 0, 32'h6000 + 4 * i, i, 1, 5'd7, i); tick();
    end
    chk("prerst_count", 32'(cnt0), 7);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all();
    chk("rst_pc", pc0, 0);
    @(posedge clk_in);
    #1 reset = 1'b0;
    set_in(1, 0, 0, 32'h5000, 32'h5, 1, 5'd6, 32'h56); tick();
    chk("postrst_pc", pc0, 32'h5000);
    chk("postrst_count", 32'(cnt0), 1);

    // Random traffic: stalled first half fills the FIFOs, second half mostly drains.
    for (int n = 0; n < 800; n++) begin
      set_in(($urandom % 4) != 0, ($urandom % 60) == 0,
             (n < 400) ? (($urandom % 3) == 0) : (($urandom % 3) != 0),
             $urandom, $urandom, $urandom % 2, 5'($urandom_range(0, 3)), $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
